// File: rtl/triumph_pkg.sv
// rtl/triumph_pkg.sv - shared types, opcodes and helpers for the Triumph ID stage
package triumph_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SLT  = 4'd3,
        ALU_SLTU = 4'd4,
        ALU_XOR  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_OR   = 4'd8,
        ALU_AND  = 4'd9,
        ALU_LUI  = 4'd10
    } alu_op_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        alu_op_e     alu_op;
        logic [31:0] imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        use_rs1;
        logic        use_rs2;
        logic        rd_we;
        logic        use_imm;
        logic        use_pc;
        logic        load;
        logic        store;
        logic        branch;
        logic        jump;
        logic        illegal;
    } id_dec_t;

    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_sel_e sel);
        case (sel)
            IMM_S:   gen_imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   gen_imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   gen_imm = {inst[31:12], 12'b0};
            IMM_J:   gen_imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: gen_imm = {{20{inst[31]}}, inst[31:20]};
        endcase
    endfunction

    // alt selects SUB over ADD and SRA over SRL (funct7 bit 5)
    function automatic alu_op_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_f3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_f3 = ALU_SLL;
            3'b010:  alu_from_f3 = ALU_SLT;
            3'b011:  alu_from_f3 = ALU_SLTU;
            3'b100:  alu_from_f3 = ALU_XOR;
            3'b101:  alu_from_f3 = alt ? ALU_SRA : ALU_SRL;
            3'b110:  alu_from_f3 = ALU_OR;
            default: alu_from_f3 = ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/triumph_decoder.sv
// rtl/triumph_decoder.sv - combinational RV32I instruction decoder
module triumph_decoder
    import triumph_pkg::*;
(
    input  logic [31:0] instr_i,
    output id_dec_t     dec_o
);

    logic [6:0] opcode;
    logic [2:0] f3;
    logic [6:0] f7;
    imm_sel_e   sel;

    assign opcode = instr_i[6:0];
    assign f3     = instr_i[14:12];
    assign f7     = instr_i[31:25];

    always_comb begin
        sel        = IMM_I;
        dec_o      = '0;
        dec_o.alu_op = ALU_ADD;
        dec_o.rs1  = instr_i[19:15];
        dec_o.rd   = instr_i[11:7];
        case (opcode)
            OPC_LUI: begin
                dec_o.alu_op = ALU_LUI;
                sel = IMM_U;
                dec_o.rs1 = '0;
                dec_o.use_imm = 1'b1;
                dec_o.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                sel = IMM_U;
                dec_o.rs1 = '0;
                {dec_o.use_imm, dec_o.use_pc, dec_o.rd_we} = 3'b111;
            end
            OPC_JAL: begin
                sel = IMM_J;
                dec_o.rs1 = '0;
                {dec_o.use_imm, dec_o.use_pc, dec_o.rd_we, dec_o.jump} = 4'b1111;
            end
            OPC_JALR: begin
                {dec_o.use_rs1, dec_o.use_imm, dec_o.rd_we, dec_o.jump} = 4'b1111;
                dec_o.illegal = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                sel = IMM_B;
                dec_o.rs2 = instr_i[24:20];
                {dec_o.use_rs1, dec_o.use_rs2, dec_o.branch} = 3'b111;
                dec_o.alu_op  = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
                dec_o.illegal = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                {dec_o.use_rs1, dec_o.use_imm, dec_o.rd_we, dec_o.load} = 4'b1111;
                dec_o.illegal = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                sel = IMM_S;
                dec_o.rs2 = instr_i[24:20];
                {dec_o.use_rs1, dec_o.use_rs2, dec_o.use_imm, dec_o.store} = 4'b1111;
                dec_o.illegal = f3[2] || (f3[1:0] == 2'b11);
            end
            OPC_OPIMM: begin
                {dec_o.use_rs1, dec_o.use_imm, dec_o.rd_we} = 3'b111;
                dec_o.alu_op  = alu_from_f3(f3, (f3 == 3'b101) && f7[5]);
                dec_o.illegal = ((f3 == 3'b001) && (f7 != 7'b0)) ||
                                ((f3 == 3'b101) && (f7 != 7'b0) && (f7 != 7'b0100000));
            end
            OPC_OP: begin
                dec_o.rs2 = instr_i[24:20];
                {dec_o.use_rs1, dec_o.use_rs2, dec_o.rd_we} = 3'b111;
                dec_o.alu_op  = alu_from_f3(f3, f7[5]);
                dec_o.illegal = !((f7 == 7'b0) ||
                                  ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_MISC, OPC_SYSTEM: begin
            end
            default: dec_o.illegal = 1'b1;
        endcase
        dec_o.imm = gen_imm(instr_i, sel);
        // an illegal op travels down the pipe with no side effects
        if (dec_o.illegal) begin
            dec_o.alu_op = ALU_ADD;
            {dec_o.use_rs1, dec_o.use_rs2, dec_o.rd_we, dec_o.use_imm, dec_o.use_pc} = 5'b0;
            {dec_o.load, dec_o.store, dec_o.branch, dec_o.jump} = 4'b0;
        end
    end

endmodule

// File: rtl/triumph_id_stage.sv
// rtl/triumph_id_stage.sv - RV32I decode stage with ID slot, scoreboard and ID/EX register
module triumph_id_stage
    import triumph_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        instr_valid_if_i,
    input  logic [31:0] instr_if_i,
    input  logic [31:0] pc_if_i,
    output logic        instr_ready_id_o,
    input  logic        flush_i,
    input  logic        wb_valid_i,
    input  logic [4:0]  wb_rd_addr_i,
    output logic [4:0]  rs1_addr_ex_o,
    output logic [4:0]  rs2_addr_ex_o,
    output logic [4:0]  rd_addr_ex_o,
    output logic        valid_ex_o,
    input  logic        ready_ex_i,
    output logic [3:0]  alu_op_ex_o,
    output logic [31:0] imm_ex_o,
    output logic [31:0] pc_ex_o,
    output logic        use_imm_ex_o,
    output logic        use_pc_ex_o,
    output logic        rd_we_ex_o,
    output logic        load_ex_o,
    output logic        store_ex_o,
    output logic        branch_ex_o,
    output logic        jump_ex_o,
    output logic        illegal_ex_o
);

    logic        id_valid_q, id_valid_d;
    logic [31:0] id_instr_q, id_instr_d;
    logic [31:0] id_pc_q, id_pc_d;
    logic [31:0] busy_q, busy_d;
    id_dec_t     dec;
    logic        hazard, issue;

    logic        valid_ex_q, use_imm_q, use_pc_q, rd_we_q, load_q, store_q, branch_q, jump_q, illegal_q;
    logic [4:0]  rs1_q, rs2_q, rd_q;
    alu_op_e     alu_q;
    logic [31:0] imm_q, pc_q;

    triumph_decoder u_decoder (
        .instr_i (id_instr_q),
        .dec_o   (dec)
    );

    assign hazard = (dec.use_rs1 && (dec.rs1 != 5'd0) && busy_q[dec.rs1]) ||
                    (dec.use_rs2 && (dec.rs2 != 5'd0) && busy_q[dec.rs2]) ||
                    (dec.rd_we   && (dec.rd  != 5'd0) && busy_q[dec.rd]);
    assign issue  = id_valid_q && !hazard && (!valid_ex_q || ready_ex_i);
    assign instr_ready_id_o = !flush_i && (!id_valid_q || issue);

    always_comb begin
        id_valid_d = id_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        if (flush_i) begin
            id_valid_d = 1'b0;
        end else if (instr_valid_if_i && instr_ready_id_o) begin
            id_valid_d = 1'b1;
            id_instr_d = instr_if_i;
            id_pc_d    = pc_if_i;
        end else if (issue) begin
            id_valid_d = 1'b0;
        end
    end

    // set is applied after clear so a same-cycle collision leaves the bit busy
    always_comb begin
        busy_d = busy_q;
        if (wb_valid_i && (wb_rd_addr_i != 5'd0)) busy_d[wb_rd_addr_i] = 1'b0;
        if (issue && dec.rd_we && (dec.rd != 5'd0)) busy_d[dec.rd] = 1'b1;
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            id_valid_q <= 1'b0;
            id_instr_q <= '0;
            id_pc_q    <= '0;
            busy_q     <= '0;
        end else begin
            id_valid_q <= id_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            busy_q     <= busy_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            valid_ex_q <= 1'b0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            alu_q      <= ALU_ADD;
            imm_q      <= '0;
            pc_q       <= '0;
            {use_imm_q, use_pc_q, rd_we_q, load_q, store_q, branch_q, jump_q, illegal_q} <= '0;
        end else if (issue) begin
            valid_ex_q <= 1'b1;
            rs1_q      <= dec.rs1;
            rs2_q      <= dec.rs2;
            rd_q       <= dec.rd;
            alu_q      <= dec.alu_op;
            imm_q      <= dec.imm;
            pc_q       <= id_pc_q;
            {use_imm_q, use_pc_q, rd_we_q, load_q, store_q, branch_q, jump_q, illegal_q} <=
                {dec.use_imm, dec.use_pc, dec.rd_we, dec.load, dec.store, dec.branch, dec.jump, dec.illegal};
        end else if (ready_ex_i) begin
            valid_ex_q <= 1'b0;
        end
    end

    assign valid_ex_o    = valid_ex_q;
    assign rs1_addr_ex_o = rs1_q;
    assign rs2_addr_ex_o = rs2_q;
    assign rd_addr_ex_o  = rd_q;
    assign alu_op_ex_o   = alu_q;
    assign imm_ex_o      = imm_q;
    assign pc_ex_o       = pc_q;
    assign use_imm_ex_o  = use_imm_q;
    assign use_pc_ex_o   = use_pc_q;
    assign rd_we_ex_o    = rd_we_q;
    assign load_ex_o     = load_q;
    assign store_ex_o    = store_q;
    assign branch_ex_o   = branch_q;
    assign jump_ex_o     = jump_q;
    assign illegal_ex_o  = illegal_q;

endmodule

// File: tb/tb_triumph_id_stage.sv
// tb/tb_triumph_id_stage.sv - directed vector bench for triumph_id_stage
module tb_triumph_id_stage;
    import triumph_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr, pc;
    logic        instr_ready;
    logic        flush;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [4:0]  rs1_ex, rs2_ex, rd_ex;
    logic        valid_ex, ready_ex;
    logic [3:0]  alu_ex;
    logic [31:0] imm_ex, pc_ex;
    logic        use_imm, use_pc, rd_we, load, store, branch, jump, illegal;

    int n_cmp = 0;
    int n_bad = 0;

    triumph_id_stage dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .instr_valid_if_i (instr_valid),
        .instr_if_i       (instr),
        .pc_if_i          (pc),
        .instr_ready_id_o (instr_ready),
        .flush_i          (flush),
        .wb_valid_i       (wb_valid),
        .wb_rd_addr_i     (wb_rd),
        .rs1_addr_ex_o    (rs1_ex),
        .rs2_addr_ex_o    (rs2_ex),
        .rd_addr_ex_o     (rd_ex),
        .valid_ex_o       (valid_ex),
        .ready_ex_i       (ready_ex),
        .alu_op_ex_o      (alu_ex),
        .imm_ex_o         (imm_ex),
        .pc_ex_o          (pc_ex),
        .use_imm_ex_o     (use_imm),
        .use_pc_ex_o      (use_pc),
        .rd_we_ex_o       (rd_we),
        .load_ex_o        (load),
        .store_ex_o       (store),
        .branch_ex_o      (branch),
        .jump_ex_o        (jump),
        .illegal_ex_o     (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic [3:0]  alu;
        logic [31:0] imm;
        logic        chk_imm;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [7:0]  flags;   // use_imm,use_pc,rd_we,load,store,branch,jump,illegal
    } vec_t;

    localparam int NV = 14;
    vec_t vecs[NV];

    function automatic logic [7:0] act_flags();
        return {use_imm, use_pc, rd_we, load, store, branch, jump, illegal};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wb_pulse(input logic [4:0] rd);
        wb_valid = 1'b1;
        wb_rd    = rd;
        step();
        wb_valid = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{32'h00700293, ALU_ADD,  32'h00000007, 1'b1, 5'd0,  5'd0,  5'd5,  8'b10100000};
        vecs[1]  = '{32'hFE208EE3, ALU_SUB,  32'hFFFFFFFC, 1'b1, 5'd1,  5'd2,  5'd29, 8'b00000100};
        vecs[2]  = '{32'h0000007F, ALU_ADD,  32'h00000000, 1'b1, 5'd0,  5'd0,  5'd0,  8'b00000001};
        vecs[3]  = '{32'h12345537, ALU_LUI,  32'h12345000, 1'b1, 5'd0,  5'd0,  5'd10, 8'b10100000};
        vecs[4]  = '{32'hFFFFF097, ALU_ADD,  32'hFFFFF000, 1'b1, 5'd0,  5'd0,  5'd1,  8'b11100000};
        vecs[5]  = '{32'h008000EF, ALU_ADD,  32'h00000008, 1'b1, 5'd0,  5'd0,  5'd1,  8'b11100010};
        vecs[6]  = '{32'hFF812383, ALU_ADD,  32'hFFFFFFF8, 1'b1, 5'd2,  5'd0,  5'd7,  8'b10110000};
        vecs[7]  = '{32'h00322623, ALU_ADD,  32'h0000000C, 1'b1, 5'd4,  5'd3,  5'd12, 8'b10001000};
        vecs[8]  = '{32'h40A48433, ALU_SUB,  32'h00000000, 1'b0, 5'd9,  5'd10, 5'd8,  8'b00100000};
        vecs[9]  = '{32'h40365593, ALU_SRA,  32'h00000403, 1'b1, 5'd12, 5'd0,  5'd11, 8'b10100000};
        vecs[10] = '{32'hFFF73693, ALU_SLTU, 32'hFFFFFFFF, 1'b1, 5'd14, 5'd0,  5'd13, 8'b10100000};
        vecs[11] = '{32'h02000033, ALU_ADD,  32'h00000000, 1'b0, 5'd0,  5'd0,  5'd0,  8'b00000001};
        vecs[12] = '{32'h00000073, ALU_ADD,  32'h00000000, 1'b1, 5'd0,  5'd0,  5'd0,  8'b00000000};
        vecs[13] = '{32'h004280E7, ALU_ADD,  32'h00000004, 1'b1, 5'd5,  5'd0,  5'd1,  8'b10100010};

        rst_n = 1'b0; instr_valid = 1'b0; instr = '0; pc = '0;
        flush = 1'b0; wb_valid = 1'b0; wb_rd = '0; ready_ex = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_valid_ex", 32'(valid_ex), 32'd0);
        chk("rst_alu", 32'(alu_ex), 32'(ALU_ADD));
        chk("rst_imm", imm_ex, 32'd0);
        chk("rst_addrs", 32'({rs1_ex, rs2_ex, rd_ex}), 32'd0);
        chk("rst_flags", 32'(act_flags()), 32'd0);
        step();

        // decode table: each op alone, exact two-cycle latency
        for (int i = 0; i < NV; i++) begin
            instr_valid = 1'b1;
            instr = vecs[i].instr;
            pc = 32'h100 + 32'(i) * 4;
            @(negedge clk);
            chk($sformatf("v%0d_accept", i), 32'(instr_ready), 32'd1);
            step();
            instr_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("v%0d_early", i), 32'(valid_ex), 32'd0);
            step();
            @(negedge clk);
            chk($sformatf("v%0d_valid", i), 32'(valid_ex), 32'd1);
            chk($sformatf("v%0d_alu", i), 32'(alu_ex), 32'(vecs[i].alu));
            if (vecs[i].chk_imm) chk($sformatf("v%0d_imm", i), imm_ex, vecs[i].imm);
            chk($sformatf("v%0d_rs1", i), 32'(rs1_ex), 32'(vecs[i].rs1));
            chk($sformatf("v%0d_rs2", i), 32'(rs2_ex), 32'(vecs[i].rs2));
            chk($sformatf("v%0d_rd", i), 32'(rd_ex), 32'(vecs[i].rd));
            chk($sformatf("v%0d_flags", i), 32'(act_flags()), 32'(vecs[i].flags));
            chk($sformatf("v%0d_pc", i), pc_ex, 32'h100 + 32'(i) * 4);
            step();
            if (vecs[i].flags[5] && vecs[i].rd != 5'd0) wb_pulse(vecs[i].rd);
        end

        // RAW stall on x5 and release one cycle after writeback
        instr_valid = 1'b1; instr = 32'h00700293; pc = 32'h200;
        step();
        instr = 32'h00528333; pc = 32'h204;
        @(negedge clk);
        chk("raw_accept_add", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("raw_addi_rd", 32'(rd_ex), 32'd5);
        chk("raw_stall_ready", 32'(instr_ready), 32'd0);
        for (int k = 0; k < 3; k++) begin
            step();
            @(negedge clk);
            chk($sformatf("raw_hold%0d", k), 32'({valid_ex, instr_ready}), 32'd0);
        end
        step();
        wb_valid = 1'b1; wb_rd = 5'd5;
        @(negedge clk);
        chk("raw_wb_cycle", 32'(valid_ex), 32'd0);
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("raw_release_noissue_yet", 32'(valid_ex), 32'd0);
        chk("raw_release_ready", 32'(instr_ready), 32'd1);
        step();
        @(negedge clk);
        chk("raw_add_valid", 32'(valid_ex), 32'd1);
        chk("raw_add_regs", 32'({rs1_ex, rs2_ex, rd_ex}), 32'({5'd5, 5'd5, 5'd6}));
        step();
        wb_pulse(5'd6);

        // EX backpressure: three ops offered, none lost
        instr_valid = 1'b1; instr = 32'h00100093; pc = 32'h300;
        step();
        instr = 32'h00200113; pc = 32'h304; ready_ex = 1'b0;
        @(negedge clk);
        chk("bp_accept_i2", 32'(instr_ready), 32'd1);
        step();
        instr = 32'h00300193; pc = 32'h308;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("bp_hold%0d", k), {valid_ex, instr_ready, 25'd0, rd_ex}, {1'b1, 1'b0, 25'd0, 5'd1});
            chk($sformatf("bp_imm%0d", k), imm_ex, 32'd1);
            step();
        end
        ready_ex = 1'b1;
        @(negedge clk);
        chk("bp_resume_ready", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("bp_i2", {valid_ex, 26'd0, rd_ex}, {1'b1, 26'd0, 5'd2});
        chk("bp_i2_pc", pc_ex, 32'h304);
        step();
        @(negedge clk);
        chk("bp_i3", {valid_ex, 26'd0, rd_ex}, {1'b1, 26'd0, 5'd3});
        step();
        @(negedge clk);
        chk("bp_drain", 32'(valid_ex), 32'd0);
        wb_pulse(5'd1);
        wb_pulse(5'd2);
        wb_pulse(5'd3);

        // flush a stalled op: dropped, but busy[5] survives
        instr_valid = 1'b1; instr = 32'h00700293; pc = 32'h400;
        step();
        instr = 32'h00528333; pc = 32'h404;
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("fl_stalled", 32'(instr_ready), 32'd0);
        step();
        flush = 1'b1;
        instr_valid = 1'b1; instr = 32'h000283B3; pc = 32'h408;
        @(negedge clk);
        chk("fl_blocks_accept", 32'(instr_ready), 32'd0);
        step();
        flush = 1'b0;
        @(negedge clk);
        chk("fl_slot_empty", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("fl_busy_kept", 32'({valid_ex, instr_ready}), 32'd0);
        step();
        wb_valid = 1'b1; wb_rd = 5'd5;
        @(negedge clk);
        chk("fl_wait0", 32'(valid_ex), 32'd0);
        step();
        wb_valid = 1'b0;
        @(negedge clk);
        chk("fl_wait1", 32'(valid_ex), 32'd0);
        step();
        @(negedge clk);
        chk("fl_x7_issued", {valid_ex, 26'd0, rd_ex}, {1'b1, 26'd0, 5'd7});
        chk("fl_x7_pc", pc_ex, 32'h408);
        step();
        @(negedge clk);
        chk("fl_no_ghost", 32'(valid_ex), 32'd0);
        step();
        wb_pulse(5'd7);

        // asynchronous reset in the middle of a stall
        ready_ex = 1'b0;
        instr_valid = 1'b1; instr = 32'h00700293; pc = 32'h500;
        step();
        instr = 32'h00528333; pc = 32'h504;
        step();
        instr_valid = 1'b0;
        @(negedge clk);
        chk("ar_pre_valid", 32'({valid_ex, instr_ready}), 32'b10);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid_ex", 32'(valid_ex), 32'd0);
        chk("ar_addrs", 32'({rs1_ex, rs2_ex, rd_ex}), 32'd0);
        chk("ar_imm_pc", imm_ex | pc_ex, 32'd0);
        chk("ar_alu", 32'(alu_ex), 32'(ALU_ADD));
        chk("ar_flags", 32'(act_flags()), 32'd0);
        chk("ar_ready", 32'(instr_ready), 32'd1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        ready_ex = 1'b1;
        instr_valid = 1'b1; instr = 32'h00528333; pc = 32'h600;
        @(negedge clk);
        chk("ar_post_accept", 32'(instr_ready), 32'd1);
        step();
        instr_valid = 1'b0;
        step();
        @(negedge clk);
        chk("ar_busy_cleared", {valid_ex, 26'd0, rd_ex}, {1'b1, 26'd0, 5'd6});
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/triumph_id_stage.md
# triumph_id_stage

Instruction-decode stage for the Triumph RV32I pipeline, between fetch and the register file / EX stage. It accepts fetched instructions over a valid/ready handshake and decodes them into ALU control, immediate and register addresses. A 32-bit scoreboard interlocks RAW/WAW hazards against in-flight writebacks. Decoded state is held in an ID/EX register whose rs1/rs2 addresses drive the register file, so the read data lines up with `valid_ex_o`.

## Interface
- No parameters; widths fixed at XLEN=32, 32 architectural registers.
- `clk_i` in 1: clock; all state is updated on the rising edge.
- `rst_ni` in 1: asynchronous, active-low reset.
- `instr_valid_if_i` in 1: fetch offers an instruction.
- `instr_if_i` in 32: instruction word.
- `pc_if_i` in 32: PC of the instruction.
- `instr_ready_id_o` out 1: ID accepts this cycle.
- `flush_i` in 1: kill the ID-held instruction (taken branch or jump in EX).
- `wb_valid_i` in 1: writeback retires a register write.
- `wb_rd_addr_i` in 5: register being retired.
- `rs1_addr_ex_o`, `rs2_addr_ex_o` out 5: register-file read addresses, registered.
- `rd_addr_ex_o` out 5: destination register, registered.
- `valid_ex_o` out 1: ID/EX register holds a valid op.
- `ready_ex_i` in 1: EX consumes the op this cycle.
- `alu_op_ex_o` out 4: ALU operation, encoded per `triumph_pkg`.
- `imm_ex_o` out 32: sign-extended immediate.
- `pc_ex_o` out 32: PC of the op.
- `use_imm_ex_o`, `use_pc_ex_o` out 1: operand-B / operand-A select.
- `rd_we_ex_o`, `load_ex_o`, `store_ex_o`, `branch_ex_o`, `jump_ex_o`, `illegal_ex_o` out 1: op class flags.

## Operation
- Two registers: the ID slot (`id_valid_q`, `id_instr_q`, `id_pc_q`) and the ID/EX register (all `*_ex_o`).
- Fetch accept: `instr_ready_id_o = !flush_i && (!id_valid_q || issue)`.
- Issue condition: `issue = id_valid_q && !hazard && (!valid_ex_o || ready_ex_i)`.
- Hazard: set when the decoded rs1 or rs2 (if used by the op) is non-zero and busy, or when rd is non-zero, written by the op, and busy.
- Scoreboard `busy[31:1]` (bit 0 hardwired to 0):
  - Set on issue when rd_we=1 and rd≠0.
  - Clear on `wb_valid_i` for `wb_rd_addr_i`.
  - If set and clear hit the same bit in one cycle, set wins. The WAW stall makes this unreachable, but it must be implemented.
  - `wb_rd_addr_i=0` is ignored.
- Decode covers LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP, MISC-MEM and SYSTEM.
  - MISC-MEM (FENCE) and SYSTEM (ECALL/EBREAK) issue as NOPs: rd_we=0, no flags.
  - Any other opcode, or an invalid funct3/funct7 combination, issues with `illegal_ex_o=1` and rd_we=0.
- Immediates:
  - I: inst[31:20].
  - S: {inst[31:25],inst[11:7]}.
  - B: {inst[31],inst[7],inst[30:25],inst[11:8],0}.
  - U: {inst[31:12],12'b0}.
  - J: {inst[31],inst[19:12],inst[20],inst[30:21],0}.
  - All are sign-extended from inst[31].
- Address fields:
  - rs1 = inst[19:15], rs2 = inst[24:20], rd = inst[11:7].
  - For LUI, AUIPC and JAL, rs1 and rs2 are driven to 0.
  - For formats without rs2, rs2 is driven to 0.
  - STORE and BRANCH have rd_we=0.
- ID/EX register update:
  - On issue: loads the decode result and sets `valid_ex_o`.
  - Else if `ready_ex_i`: clears `valid_ex_o`, other fields hold.
  - Else: holds.
- Flush: clears `id_valid_q` at the clock edge and blocks acceptance that cycle. The ID/EX register and scoreboard are unaffected.

## Timing
- Reset values:
  - `id_valid_q=0`, `valid_ex_o=0`, `busy=0`.
  - `*_addr_ex_o=0`, `imm_ex_o=0`, `pc_ex_o=0`, `alu_op_ex_o=ALU_ADD`.
  - All flags 0.
  - `instr_ready_id_o=1` once reset is released.
- Reset asserted mid-operation discards the ID slot, the ID/EX register and the scoreboard immediately.
- Latency:
  - Instruction accepted in cycle N reaches `valid_ex_o=1` in cycle N+2 with no hazard.
  - Register-file data is valid in the same cycle as `valid_ex_o`.
- Throughput: one instruction per cycle with no hazards and `ready_ex_i=1`.
- Stall release: hazard on rd X with `wb_valid_i`/`wb_rd_addr_i=X` in cycle M → issue at the edge ending cycle M+1 (the busy bit is registered).
- `ready_ex_i=0` with `valid_ex_o=1` holds all `*_ex_o` stable and deasserts `instr_ready_id_o` once the ID slot is full.

## Structure
- `triumph_pkg` holds:
  - `alu_op_e` (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, LUI).
  - RV32I opcode constants.
  - `imm_sel_e` (I, S, B, U, J).
- Sub-module `triumph_decoder`: purely combinational, instruction → decode bundle. Scoreboard, ID slot and ID/EX register live in `triumph_id_stage`.

## Test plan
- `addi x5,x0,7` (0x00700293) at PC 0x100, `ready_ex_i=1` → two cycles later `valid_ex_o=1`, rd=5, rs1=0, imm=7, `use_imm=1`, `alu_op=ADD`, `rd_we=1`.
- `addi x5,x0,7` then `add x6,x5,x5` → second op stalls while busy[5]=1. `wb_valid_i` with rd=5 → `add` issues one cycle later.
- `beq x1,x2,-4` (0xFE208EE3) → imm=0xFFFFFFFC, `branch_ex_o=1`, `rd_we=0`, no busy bit set.
- Opcode 0x0000007F → `illegal_ex_o=1`, `rd_we=0`, pipeline continues.
- `ready_ex_i=0` for 3 cycles with 3 instructions offered → one in EX and one in the ID slot, `instr_ready_id_o=0`, outputs stable, no instruction lost.
- `flush_i` with the ID slot full → slot dropped, that op never issues, scoreboard unchanged. Assert `rst_ni` low mid-stall → all outputs at reset values asynchronously.
